// File: rtl/delay_arbiter_if.sv
// Request/grant bundle for delay_arbiter. The abort/aborted pair exists only when
// DELAY_ARBITER_ABORT_EN is defined.
interface delay_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
) ();
  logic                       enable;
  logic [N_REQ-1:0]           req;
  logic [N_REQ*CNT_W-1:0]     delay_val;
  logic [N_REQ-1:0]           gnt;
  logic [N_REQ-1:0]           done;
  logic                       busy;
  logic [$clog2(N_REQ)-1:0]   active_id;
`ifdef DELAY_ARBITER_ABORT_EN
  logic                       abort;
  logic [N_REQ-1:0]           aborted;

  modport master (
    output enable, req, delay_val, abort,
    input  gnt, done, busy, active_id, aborted
  );
  modport slave (
    input  enable, req, delay_val, abort,
    output gnt, done, busy, active_id, aborted
  );
`else
  modport master (
    output enable, req, delay_val,
    input  gnt, done, busy, active_id
  );
  modport slave (
    input  enable, req, delay_val,
    output gnt, done, busy, active_id
  );
`endif
endinterface

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that grants one requester at a time and runs its delay to expiry.
// Optional abort path enabled by defining DELAY_ARBITER_ABORT_EN.
module delay_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  delay_arbiter_if.slave bus
);
  localparam int unsigned IdW = $clog2(N_REQ);

  typedef enum logic {StIdle, StCount} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
`ifdef DELAY_ARBITER_ABORT_EN
  logic [N_REQ-1:0] aborted_q, aborted_d;
`endif

  logic             win_valid;
  logic [IdW-1:0]   win_id;

  // First requesting index found scanning upward from the priority pointer, wrapping.
  always_comb begin
    int unsigned idx;
    logic [IdW-1:0] cand;
    win_valid = 1'b0;
    win_id    = ptr_q;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IdW'(idx);
      if (!win_valid && bus.req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = '0;
    done_d  = '0;
`ifdef DELAY_ARBITER_ABORT_EN
    aborted_d = '0;
`endif
    if (bus.enable) begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            gnt_d[win_id] = 1'b1;
            cnt_d         = bus.delay_val[32'(win_id) * CNT_W +: CNT_W];
            id_d          = win_id;
            ptr_d         = (win_id == IdW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
            state_d       = StCount;
          end
        end
        StCount: begin
`ifdef DELAY_ARBITER_ABORT_EN
          if (bus.abort) begin
            aborted_d[id_q] = 1'b1;
            state_d         = StIdle;
          end else
`endif
          if (cnt_q == '0) begin
            done_d[id_q] = 1'b1;
            state_d      = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
`ifdef DELAY_ARBITER_ABORT_EN
      aborted_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
`ifdef DELAY_ARBITER_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == StCount);
  assign bus.active_id = id_q;
`ifdef DELAY_ARBITER_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each requested delay in cycles.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, a global advance qualifier; when low, all state is frozen.
REQ-006 The block SHALL have port req, input, N_REQ, a per-requester delay request held high until granted.
REQ-007 The block SHALL have port delay_val, input, N_REQ*CNT_W, the delay for requester i in slice [i*CNT_W +: CNT_W].
REQ-008 The block SHALL have port gnt, output, N_REQ, a one-hot one-cycle acceptance pulse.
REQ-009 The block SHALL have port done, output, N_REQ, a one-hot one-cycle expiry pulse.
REQ-010 The block SHALL have port busy, output, 1, which is high while a delay is running (state COUNT).
REQ-011 The block SHALL have port active_id, output, $clog2(N_REQ), the index of the current or last granted requester.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and COUNT.
REQ-013 In IDLE with enable=1 and req!=0, the clock edge SHALL do all of: select a winner; load cnt from the winner's delay_val; register gnt[winner]=1; set active_id; enter COUNT.
REQ-014 Arbitration SHALL be round-robin, with priority starting at (last_winner+1) mod N_REQ; after reset, requester 0 has the highest priority.
REQ-015 Timing SHALL be as follows: gnt is visible in cycle k, and done[active_id] is visible in cycle k+D+1, where D is the captured delay and enable is high throughout; D=0 gives done in cycle k+1.
REQ-016 In COUNT with enable=1, cnt SHALL decrement by 1 each cycle; when cnt==0, the edge SHALL register done[active_id]=1, drop busy and return to IDLE.
REQ-017 A new grant SHALL be issued no earlier than the cycle after done, so back-to-back delays have a 1-cycle IDLE gap.
REQ-018 delay_val SHALL be sampled only at grant; later changes do not affect a running delay.
REQ-019 req changes during COUNT SHALL be ignored; a req dropped before its grant is withdrawn and is never granted.
REQ-020 With enable=0, cnt, state, pointer and active_id SHALL hold, and gnt and done SHALL be 0; pulses are never stretched or repeated.
REQ-021 A delay of all-ones SHALL count 2^CNT_W-1 cycles with no wrap and no early expiry.
REQ-022 gnt and done SHALL never be high in the same cycle, and SHALL each have at most one bit set.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE with cnt=0, gnt=0, done=0, busy=0, active_id=0, and the pointer set so that requester 0 wins next; rst overrides enable.
REQ-024 A reset during COUNT SHALL abandon the running delay silently, with no done pulse.

Configuration
REQ-025 When DELAY_ARBITER_ABORT_EN is defined, the block SHALL add input abort (1 bit) and output aborted (N_REQ, one-hot pulse).
REQ-026 With DELAY_ARBITER_ABORT_EN, abort=1 in COUNT with enable=1 SHALL register aborted[active_id]=1, suppress done, and return to IDLE; abort beats expiry in the same cycle, and abort in IDLE has no effect.
REQ-027 Without DELAY_ARBITER_ABORT_EN, the abort and aborted ports SHALL not exist and every granted delay SHALL run to done.

Verification
REQ-028 Single request: req=4'b0001, delay_val[0]=5, enable=1 -> gnt=0001 in cycle k, busy in cycles k..k+5, done=0001 in cycle k+6.
REQ-029 Round-robin: req=4'b1111 held, all delays=0 -> grants occur in order 0,1,2,3,0, each followed by done one cycle later, with a 1-cycle gap between done and the next gnt.
REQ-030 Enable stall: delay=3, enable low for 4 cycles mid-count -> done arrives 4 cycles later than nominal, and no gnt or done is seen while enable is low.
REQ-031 Reset mid-count: delay=10, rst at the 3rd COUNT cycle -> no done, and all outputs are 0 on the next cycle; a subsequent req=0100 is granted to requester 2 only after requester 0 priority is checked.
REQ-032 Abort (DELAY_ARBITER_ABORT_EN only): delay=8, abort at the cycle where cnt==0 -> aborted pulses for the active requester, done stays 0, and the block returns to IDLE.
REQ-033 Boundary: CNT_W=4, delay=15 -> done at k+16; delay_val changed to 1 after grant -> no effect on timing.
